// File: rtl/fifo_destino.sv
// Destination FIFO behind the arbiter: registered read port, programmable
// almost-full (pause) / almost-empty thresholds and a sticky error flag.
module fifo_destino #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  pause,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int unsigned        DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH   = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_umbral_alto;
    logic [ADDR_WIDTH-1:0] r_umbral_bajo;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;
    logic w_err_set;

    always_comb begin
        w_full    = (r_count == LP_DEPTH);
        w_empty   = (r_count == '0);
        w_do_pop  = pop && !w_empty;
        // A valid pop frees a slot in the same cycle, so a push on a full FIFO still lands.
        w_do_push = push && (!w_full || w_do_pop);
        w_err_set = (pop && w_empty) || (push && w_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_error       <= 1'b0;
            r_umbral_alto <= umbral_alto;
            r_umbral_bajo <= umbral_bajo;
        end else begin
            r_valid_out <= w_do_pop;
            if (w_do_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - LP_CNT_ONE;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out     = r_data_out;
        valid_out    = r_valid_out;
        error        = r_error;
        full         = w_full;
        empty        = w_empty;
        pause        = (r_count >= {1'b0, r_umbral_alto});
        almost_empty = (r_count <= {1'b0, r_umbral_bajo});
    end

endmodule

// File: tb/tb_fifo_destino.sv
// Bench for fifo_destino: fixed vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fifo_destino;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset, push, pop;
    logic [DW-1:0] data_in;
    logic [AW-1:0] umbral_alto, umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out, pause, full, empty, almost_empty, error;

    fifo_destino #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .pause        (pause),
        .full         (full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid, m_err;
    int            m_hi, m_lo;

    typedef struct {
        bit            rst, psh, pp;
        logic [DW-1:0] din;
        logic [AW-1:0] ua, ub;
        logic [DW-1:0] dout;
        bit            vld, ful, emp, ae, pse, err;
    } vec_t;

    vec_t tv[16];
    logic [DW-1:0] w[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit pu, input bit po,
                                input logic [DW-1:0] din, input int ua, input int ub);
        int n;
        bit vp, vw;
        if (r) begin
            q.delete();
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_dout  = '0;
            m_hi    = ua;
            m_lo    = ub;
        end else begin
            n  = q.size();
            vp = po && (n > 0);
            vw = pu && ((n < DEPTH) || vp);
            if (po && n == 0) m_err = 1'b1;
            if (pu && n == DEPTH && !po) m_err = 1'b1;
            m_valid = vp;
            if (vp) m_dout = q.pop_front();
            if (vw) q.push_back(din);
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit po,
                        input logic [DW-1:0] din, input logic [AW-1:0] ua,
                        input logic [AW-1:0] ub);
        reset       = r;
        push        = pu;
        pop         = po;
        data_in     = din;
        umbral_alto = ua;
        umbral_bajo = ub;
        @(posedge clk);
        model_update(r, pu, po, din, int'(ua), int'(ub));
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".data_out"},     int'(data_out),     int'(m_dout));
        chk({tag, ".valid_out"},    int'(valid_out),    int'(m_valid));
        chk({tag, ".error"},        int'(error),        int'(m_err));
        chk({tag, ".full"},         int'(full),         int'(n == DEPTH));
        chk({tag, ".empty"},        int'(empty),        int'(n == 0));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= m_lo));
        chk({tag, ".pause"},        int'(pause),        int'(n >= m_hi));
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_alto = 3'd6; umbral_bajo = 3'd1;
        m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_hi = 6; m_lo = 1;
        w = '{6'h01, 6'h3e, 6'h15, 6'h2a, 6'h33, 6'h0c, 6'h27, 6'h18};

        //          rst psh pp din        ua ub  dout       vld ful emp ae pse err
        tv[0]  = '{1, 0, 0, 6'h00,      6, 1, 6'h00,      0, 0, 1, 1, 0, 0};
        tv[1]  = '{0, 1, 0, 6'b110100,  0, 0, 6'h00,      0, 0, 0, 1, 0, 0};
        tv[2]  = '{0, 1, 0, 6'b100101,  0, 0, 6'h00,      0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 1, 0, 6'b101100,  0, 0, 6'h00,      0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 1, 6'h00,      0, 0, 6'b110100,  1, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 1, 6'h00,      0, 0, 6'b100101,  1, 0, 0, 1, 0, 0};
        tv[6]  = '{0, 0, 1, 6'h00,      0, 0, 6'b101100,  1, 0, 1, 1, 0, 0};
        tv[7]  = '{0, 0, 0, 6'h00,      0, 0, 6'b101100,  0, 0, 1, 1, 0, 0};
        tv[8]  = '{0, 0, 1, 6'h00,      0, 0, 6'b101100,  0, 0, 1, 1, 0, 1};
        tv[9]  = '{0, 0, 0, 6'h00,      0, 0, 6'b101100,  0, 0, 1, 1, 0, 1};
        tv[10] = '{1, 0, 0, 6'h00,      0, 0, 6'h00,      0, 0, 1, 1, 1, 0};
        tv[11] = '{0, 1, 0, 6'b000111,  7, 7, 6'h00,      0, 0, 0, 0, 1, 0};
        tv[12] = '{0, 1, 1, 6'b010101,  0, 0, 6'b000111,  1, 0, 0, 0, 1, 0};
        tv[13] = '{1, 1, 1, 6'b111111,  6, 1, 6'h00,      0, 0, 1, 1, 0, 0};
        tv[14] = '{0, 0, 1, 6'h00,      0, 0, 6'h00,      0, 0, 1, 1, 0, 1};
        tv[15] = '{1, 0, 0, 6'h00,      6, 1, 6'h00,      0, 0, 1, 1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(tv[i].rst, tv[i].psh, tv[i].pp, tv[i].din, tv[i].ua, tv[i].ub);
            chk($sformatf("vec%0d.data_out", i),     int'(data_out),     int'(tv[i].dout));
            chk($sformatf("vec%0d.valid_out", i),    int'(valid_out),    int'(tv[i].vld));
            chk($sformatf("vec%0d.full", i),         int'(full),         int'(tv[i].ful));
            chk($sformatf("vec%0d.empty", i),        int'(empty),        int'(tv[i].emp));
            chk($sformatf("vec%0d.almost_empty", i), int'(almost_empty), int'(tv[i].ae));
            chk($sformatf("vec%0d.pause", i),        int'(pause),        int'(tv[i].pse));
            chk($sformatf("vec%0d.error", i),        int'(error),        int'(tv[i].err));
        end

        // Fill to full, overflow, drain in order
        step(1, 0, 0, 0, 6, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, w[i], 0, 0);
            chk($sformatf("fill%0d.pause", i), int'(pause), int'(i + 1 >= 6));
            chk($sformatf("fill%0d.full", i),  int'(full),  int'(i == 7));
        end
        step(0, 1, 0, 6'h3f, 0, 0);
        chk("overflow.full",  int'(full),  1);
        chk("overflow.error", int'(error), 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0, 0);
            chk($sformatf("drain%0d.data_out", i), int'(data_out),  int'(w[i]));
            chk($sformatf("drain%0d.valid", i),    int'(valid_out), 1);
        end
        chk("drain.empty", int'(empty), 1);
        chk("drain.error_sticky", int'(error), 1);

        // Push and pop together while full
        step(1, 0, 0, 0, 6, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, w[i], 0, 0);
        step(0, 1, 1, 6'h2a, 0, 0);
        chk("fullpp.data_out", int'(data_out), int'(w[0]));
        chk("fullpp.full",     int'(full),     1);
        chk("fullpp.error",    int'(error),    0);
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 1, 0, 0, 0);
            chk($sformatf("fullpp_drain%0d", i), int'(data_out), (i < 8) ? int'(w[i]) : 'h2a);
        end

        // Push and pop together at count 4
        step(1, 0, 0, 0, 6, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, w[i], 0, 0);
        step(0, 1, 1, 6'b111101, 0, 0);
        chk("mid.data_out", int'(data_out), int'(w[0]));
        chk("mid.valid",    int'(valid_out), 1);
        chk_model("mid");
        for (int i = 1; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 0);
            chk($sformatf("mid_drain%0d", i), int'(data_out), (i < 4) ? int'(w[i]) : 'h3d);
        end

        // Push and pop together while empty: no bypass
        step(1, 0, 0, 0, 6, 1);
        step(0, 1, 1, 6'h15, 0, 0);
        chk("emptypp.valid", int'(valid_out), 0);
        chk("emptypp.error", int'(error),     1);
        chk("emptypp.empty", int'(empty),     0);
        step(0, 0, 1, 0, 0, 0);
        chk("emptypp.pop_data", int'(data_out), 'h15);
        chk("emptypp.pop_valid", int'(valid_out), 1);

        // Reset mid-sequence discards contents and clears error
        for (int i = 0; i < 3; i++) step(0, 1, 0, w[i], 0, 0);
        step(1, 1, 1, 6'h2b, 6, 1);
        chk("midrst.empty", int'(empty), 1);
        chk("midrst.error", int'(error), 0);
        chk("midrst.valid", int'(valid_out), 0);

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            step(r, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 DW'($urandom), AW'($urandom), AW'($urandom));
            chk_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_destino.md
FIFO_DESTINO -- requirements
Module: fifo_destino

Interface
REQ-001 Parameter DATA_WIDTH, default 6, word width (matches arbiter D0_out/D1_out).
REQ-002 Parameter ADDR_WIDTH, default 3, address width; depth = 2**ADDR_WIDTH (8).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port data_in  input  DATA_WIDTH  word from arbiter output D0_out/D1_out.
REQ-006 Port push  input  1  write strobe from arbiter; data_in written when high and not full.
REQ-007 Port pop  input  1  read strobe from downstream consumer.
REQ-008 Port umbral_alto  input  ADDR_WIDTH  almost-full threshold, sampled during reset only.
REQ-009 Port umbral_bajo  input  ADDR_WIDTH  almost-empty threshold, sampled during reset only.
REQ-010 Port data_out  output  DATA_WIDTH  registered read data.
REQ-011 Port valid_out  output  1  data_out holds a word popped in the previous cycle.
REQ-012 Port pause  output  1  almost-full flag; drives arbiter Dx_pause.
REQ-013 Port full  output  1  occupancy == depth.
REQ-014 Port empty  output  1  occupancy == 0.
REQ-015 Port almost_empty  output  1  occupancy <= latched umbral_bajo.
REQ-016 Port error  output  1  sticky overflow/underflow flag.

Function
REQ-017 Storage: depth x DATA_WIDTH register array; wr_ptr, rd_ptr ADDR_WIDTH bits, wrap modulo depth.
REQ-018 Occupancy counter: ADDR_WIDTH+1 bits, range 0..depth.
REQ-019 Push, not full: write data_in at wr_ptr, wr_ptr+1, count+1 (unless simultaneous valid pop).
REQ-020 Pop, not empty: data_out <= mem[rd_ptr] at next posedge, valid_out=1 that cycle, rd_ptr+1, count-1.
REQ-021 Read latency: exactly one cycle pop -> data_out/valid_out; valid_out=0 in any cycle following no valid pop.
REQ-022 data_out holds last value when no valid pop.
REQ-023 Simultaneous push and pop, 0 < count < depth: both performed, count unchanged.
REQ-024 Simultaneous push and pop while empty: push performed, pop ignored, error set, valid_out=0; no write-through bypass.
REQ-025 Simultaneous push and pop while full: pop performed, push performed (slot freed same cycle), count stays depth, error not set.
REQ-026 Push while full (no pop): data dropped, pointers/count unchanged, error set.
REQ-027 Pop while empty (no push): ignored, pointers/count unchanged, error set.
REQ-028 Error: once set, remains 1 until reset.
REQ-029 Flags combinational from count and latched thresholds: full=(count==depth), empty=(count==0), pause=(count>=umbral_alto_reg), almost_empty=(count<=umbral_bajo_reg).
REQ-030 Threshold latches load umbral_alto/umbral_bajo every cycle reset is high; hold while reset low.
REQ-031 pause drives the arbiter directly; arbiter's one-cycle pause reaction absorbed by umbral_alto <= depth-1 (bench uses <= depth-2).

Reset
REQ-032 With reset high at posedge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0; thresholds loaded.
REQ-033 Outputs after reset: empty=1, full=0, almost_empty=1, pause=1 only if latched umbral_alto==0.
REQ-034 Reset mid-operation discards all stored words; mem contents need not be cleared; no push/pop takes effect in a reset cycle.

Verification
REQ-035 Reset with umbral_alto=6, umbral_bajo=1 -> empty=1, almost_empty=1, pause=0, full=0, error=0, valid_out=0.
REQ-036 Push 6'b110100, 6'b100101, 6'b101100 on 3 cycles, then pop 3 cycles -> data_out same order, each one cycle after its pop with valid_out=1; empty=1 afterwards.
REQ-037 Push 6 words -> pause rises on cycle count reaches 6; 2 more pushes -> full=1; 9th push -> dropped, error=1; pop 8 -> original 8 words in order.
REQ-038 count=4, push 6'b111101 with pop together -> count stays 4, popped word = oldest; flags unchanged.
REQ-039 Empty FIFO, pop=1 for one cycle -> valid_out=0, error=1, pointers unchanged; error stays 1 until reset.
REQ-040 Write 10 words with interleaved pops (pointer wrap past 7) -> order preserved; reset mid-sequence -> empty=1, error=0 on next cycle.
